int8_dot_accum_seq: RTL

// Sequencer/accumulator that sits directly downstream of int8_mac_pp_feedback:
//   - registers the MAC result and feeds it back as the accumulator operand;
//   - walks a stream of int8 operand pairs to form a signed 16-bit dot product.
// One pair is consumed per accepted beat; the final sum is handed off on a valid/ready output.

---
 rtl/int8_dot_accum_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/int8_dot_accum_seq.sv
// rtl/int8_dot_accum_seq.sv - int8 dot-product sequencer/accumulator wrapped around an external MAC
// Optional sticky signed-overflow detection is enabled by defining INT8_DOT_OVF_EN.
module int8_dot_accum_seq #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic [LEN_W-1:0] len,
   input  logic [ACC_W-1:0] init_acc,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic [7:0]       mac_multiplicand,
   output logic [7:0]       mac_multiplier,
   output logic [ACC_W-1:0] mac_accumulator,
   input  logic [ACC_W-1:0] mac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [LEN_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic             w_accept;
   logic             w_start;

   assign w_accept = r_in_ready & in_valid;
   assign w_start  = (r_state == S_IDLE) & start;

   assign mac_multiplicand = in_a;
   assign mac_multiplier   = in_b;
   assign mac_accumulator  = r_acc;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_data  = r_acc;

   // Handshake outputs are registered alongside the state so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (clear) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc  <= init_acc;
                  r_cnt  <= len;
                  r_busy <= 1'b1;
                  if (len == '0) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state    <= S_RUN;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_acc <= mac_result;
                  r_cnt <= r_cnt - LEN_W'(1);
                  if (r_cnt == LEN_W'(1)) begin
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef INT8_DOT_OVF_EN
   logic w_psign;
   logic w_ovf_beat;
   logic r_ovf;

   // A zero product counts as non-negative, so it can never flag overflow.
   assign w_psign    = (in_a[7] ^ in_b[7]) & (in_a != 8'd0) & (in_b != 8'd0);
   assign w_ovf_beat = (w_psign == r_acc[ACC_W-1]) & (mac_result[ACC_W-1] != r_acc[ACC_W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (clear || w_start) begin
         r_ovf <= 1'b0;
      end else if ((r_state == S_RUN) && w_accept) begin
         r_ovf <= r_ovf | w_ovf_beat;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

endmodule
